// File: rtl/maxpool2x2_layer1_if.sv
// maxpool2x2_layer1_if: pixel stream in, pooled stream out.
// master drives the conv stream; slave is the pooling block.
interface maxpool2x2_layer1_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_ch0;
    logic [DATA_W-1:0] in_ch1;
    logic [DATA_W-1:0] in_ch2;
    logic [DATA_W-1:0] in_ch3;
    logic [DATA_W-1:0] in_ch4;
    logic [DATA_W-1:0] in_ch5;
    logic [DATA_W-1:0] in_ch6;
    logic [DATA_W-1:0] in_ch7;
    logic              out_valid;
    logic [DATA_W-1:0] out_pool0;
    logic [DATA_W-1:0] out_pool1;
    logic [DATA_W-1:0] out_pool2;
    logic [DATA_W-1:0] out_pool3;
    logic [DATA_W-1:0] out_pool4;
    logic [DATA_W-1:0] out_pool5;
    logic [DATA_W-1:0] out_pool6;
    logic [DATA_W-1:0] out_pool7;
    logic              frame_done;

    modport master (
        output in_valid,
        output in_ch0, in_ch1, in_ch2, in_ch3,
        output in_ch4, in_ch5, in_ch6, in_ch7,
        input  out_valid,
        input  out_pool0, out_pool1, out_pool2, out_pool3,
        input  out_pool4, out_pool5, out_pool6, out_pool7,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_ch0, in_ch1, in_ch2, in_ch3,
        input  in_ch4, in_ch5, in_ch6, in_ch7,
        output out_valid,
        output out_pool0, out_pool1, out_pool2, out_pool3,
        output out_pool4, out_pool5, out_pool6, out_pool7,
        output frame_done
    );
endinterface

// File: rtl/maxpool2x2_layer1.sv
// maxpool2x2_layer1: 2x2/stride-2 max pooling over 8 channels.
// Optional end-of-frame pulse: define MAXPOOL_FRAME_DONE_EN.
module maxpool2x2_layer1 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int CH     = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    maxpool2x2_layer1_if.slave  bus
);
    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [DATA_W-1:0] sample_t;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-2:0] rb_idx;
    logic          col_odd;
    logic          row_odd;
    logic          col_last;
    logic          row_last;
    logic          hwr;
    logic          vout;

    sample_t in_s   [CH];
    sample_t hold   [CH];
    sample_t hmax   [CH];
    sample_t rb_rd  [CH];
    sample_t vmax   [CH];
    sample_t pool_q [CH];
    sample_t rowbuf [HALF_W][CH];

    logic out_valid_q;

    assign in_s[0] = bus.in_ch0;
    assign in_s[1] = bus.in_ch1;
    assign in_s[2] = bus.in_ch2;
    assign in_s[3] = bus.in_ch3;
    assign in_s[4] = bus.in_ch4;
    assign in_s[5] = bus.in_ch5;
    assign in_s[6] = bus.in_ch6;
    assign in_s[7] = bus.in_ch7;

    assign col_odd  = col_cnt[0];
    assign row_odd  = row_cnt[0];
    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);
    assign rb_idx   = col_cnt[CW-1:1];

    // Even-row odd-column beats fill the row buffer; odd-row ones emit.
    assign hwr  = bus.in_valid && col_odd && !row_odd;
    assign vout = bus.in_valid && col_odd && row_odd;

    // Raster position of the next incoming pixel; frames run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.in_valid) begin
            unique case (1'b1)
                col_last && row_last: begin
                    col_cnt <= '0;
                    row_cnt <= '0;
                end
                col_last && !row_last: begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 1'b1;
                end
                !col_last: begin
                    col_cnt <= col_cnt + 1'b1;
                end
            endcase
        end
    end

    // Horizontal and vertical maxima; the two stages are pure compares.
    always_comb begin
        for (int ch = 0; ch < CH; ch++) begin
            hmax[ch]  = (in_s[ch] > hold[ch]) ? in_s[ch] : hold[ch];
            rb_rd[ch] = rowbuf[rb_idx][ch];
            vmax[ch]  = (rb_rd[ch] > hmax[ch]) ? rb_rd[ch] : hmax[ch];
        end
    end

    // Left pixel of each horizontal pair is held for the right one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CH; ch++) begin
                hold[ch] <= '0;
            end
        end else if (bus.in_valid && !col_odd) begin
            for (int ch = 0; ch < CH; ch++) begin
                hold[ch] <= in_s[ch];
            end
        end
    end

    // Row buffer: contents are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (hwr) begin
            for (int ch = 0; ch < CH; ch++) begin
                rowbuf[rb_idx][ch] <= hmax[ch];
            end
        end
    end

    // Registered pooled output; values hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            for (int ch = 0; ch < CH; ch++) begin
                pool_q[ch] <= '0;
            end
        end else begin
            out_valid_q <= vout;
            if (vout) begin
                for (int ch = 0; ch < CH; ch++) begin
                    pool_q[ch] <= vmax[ch];
                end
            end
        end
    end

`ifdef MAXPOOL_FRAME_DONE_EN
    logic frame_done_q;

    // Pulse alongside the last pooled pixel of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= vout && col_last && row_last;
        end
    end

    assign bus.frame_done = frame_done_q;
`else
    assign bus.frame_done = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_pool0 = pool_q[0];
    assign bus.out_pool1 = pool_q[1];
    assign bus.out_pool2 = pool_q[2];
    assign bus.out_pool3 = pool_q[3];
    assign bus.out_pool4 = pool_q[4];
    assign bus.out_pool5 = pool_q[5];
    assign bus.out_pool6 = pool_q[6];
    assign bus.out_pool7 = pool_q[7];
endmodule

// File: tb/tb_maxpool2x2_layer1.sv
// tb_maxpool2x2_layer1: directed frames against an image-level
// pooling model plus literal expectations for selected pixels.
module tb_maxpool2x2_layer1;
    localparam int W = 28;
    localparam int H = 28;
`ifdef MAXPOOL_FRAME_DONE_EN
    localparam bit FD_EN = 1'b1;
`else
    localparam bit FD_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [63:0] val;
        bit          last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    int   fd_cnt;

    exp_t        q[$];
    logic [63:0] obs[$];
    logic [63:0] img [H][W];
    logic [63:0] last_out;
    logic [63:0] pools;

    maxpool2x2_layer1_if #(.DATA_W(8)) bus ();

    maxpool2x2_layer1 #(
        .IMG_W(W), .IMG_H(H), .CH(8), .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign pools = {bus.out_pool7, bus.out_pool6,
                    bus.out_pool5, bus.out_pool4,
                    bus.out_pool3, bus.out_pool2,
                    bus.out_pool1, bus.out_pool0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm,
                         input logic [65:0] act,
                         input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pix(int mode, int p, int r, int c);
        logic [63:0] v;
        v = '0;
        case (mode)
            0: v[7:0] = 8'((r * 28 + c) % 128);
            1: if (r == 6 + p / 2 && c == 8 + p % 2) v[31:24] = 8'd100;
            default: for (int k = 0; k < 8; k++) v[8*k +: 8] = 8'(10 * k + 5);
        endcase
        return v;
    endfunction

    // Expected pooled pixel: per-channel max over the 2x2 cell of the image.
    function automatic logic [63:0] pmax(int r, int c);
        logic [63:0] v;
        logic [7:0]  m;
        logic [7:0]  e;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            m = 8'd0;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    e = img[r-dr][c-dc][8*k +: 8];
                    if (e > m) m = e;
                end
            end
            v[8*k +: 8] = m;
        end
        return v;
    endfunction

    function automatic logic [63:0] obs_at(int i);
        return (i < obs.size()) ? obs[i] : '1;
    endfunction

    task automatic set_in(input logic [63:0] v);
        bus.in_ch0 = v[7:0];
        bus.in_ch1 = v[15:8];
        bus.in_ch2 = v[23:16];
        bus.in_ch3 = v[31:24];
        bus.in_ch4 = v[39:32];
        bus.in_ch5 = v[47:40];
        bus.in_ch6 = v[55:48];
        bus.in_ch7 = v[63:56];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int mode, input int p,
                              input int gap, input int ab_r,
                              input int ab_c);
        logic [63:0] v;
        exp_t        e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == ab_r && c == ab_c) begin
                    do_reset();
                    return;
                end
                @(posedge clk); #1;
                bus.in_valid = 1'b1;
                v = pix(mode, p, r, c);
                set_in(v);
                img[r][c] = v;
                if (r % 2 == 1 && c % 2 == 1) begin
                    e.due  = cyc + 1;
                    e.val  = pmax(r, c);
                    e.last = (r == H - 1 && c == W - 1);
                    q.push_back(e);
                end
                repeat (gap) begin
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                    set_in({$urandom, $urandom});
                end
            end
        end
    endtask

    // Every cycle: outputs must match the model, or hold, or read zero in reset.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset", {bus.out_valid, bus.frame_done, pools}, '0);
            last_out = '0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("valid", {65'd0, bus.out_valid}, 66'd1);
            check("pool", {2'b0, pools}, {2'b0, e.val});
            check("frame_done", {65'd0, bus.frame_done},
                  {65'd0, e.last && FD_EN});
            last_out = e.val;
        end else begin
            check("idle", {bus.out_valid, bus.frame_done, pools},
                  {2'b00, last_out});
        end
        if (rst_n && bus.out_valid) begin
            obs.push_back(pools);
            if (bus.frame_done) fd_cnt++;
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        fd_cnt   = 0;
        last_out = '0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        set_in('0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        obs.delete(); fd_cnt = 0;
        send_frame(0, 0, 0, -1, -1);
        idle(3);
        check("ramp_first", {58'd0, obs_at(0)[7:0]}, 66'd29);
        check("ramp_second", {58'd0, obs_at(1)[7:0]}, 66'd31);
        check("ramp_count", 66'(obs.size()), 66'd196);
        check("ramp_fd", 66'(fd_cnt), FD_EN ? 66'd1 : 66'd0);

        for (int p = 0; p < 4; p++) begin
            obs.delete();
            send_frame(1, p, 0, -1, -1);
            idle(3);
            check("sweep_hit", {58'd0, obs_at(46)[31:24]}, 66'd100);
            check("sweep_other", {2'b0, obs_at(45)}, 66'd0);
        end

        obs.delete();
        send_frame(2, 0, 0, -1, -1);
        idle(3);
        check("chan_const", {2'b0, obs_at(195)},
              {2'b0, 64'h4B41372D23190F05});

        obs.delete(); fd_cnt = 0;
        send_frame(0, 0, 3, -1, -1);
        idle(3);
        check("gap_first", {58'd0, obs_at(0)[7:0]}, 66'd29);
        check("gap_second", {58'd0, obs_at(1)[7:0]}, 66'd31);
        check("gap_count", 66'(obs.size()), 66'd196);

        send_frame(0, 0, 0, 9, 5);
        obs.delete(); fd_cnt = 0;
        send_frame(0, 0, 0, -1, -1);
        send_frame(2, 0, 0, -1, -1);
        idle(3);
        check("b2b_count", 66'(obs.size()), 66'd392);
        check("b2b_first", {58'd0, obs_at(0)[7:0]}, 66'd29);
        check("b2b_chan", {2'b0, obs_at(196)},
              {2'b0, 64'h4B41372D23190F05});
        check("b2b_fd", 66'(fd_cnt), FD_EN ? 66'd2 : 66'd0);
        check("queue_empty", 66'(q.size()), 66'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
